// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM interface: arbiter states, SDRAM command nibbles
// ({cs_n,ras_n,cas_n,we_n}) and the idle bus value driven between grants.
package sdram_pkg;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    localparam logic [3:0] CMD_NOP                = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE          = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH       = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE_REGISTER = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE             = 4'b0011;
    localparam logic [3:0] CMD_WRITE              = 4'b0100;
    localparam logic [3:0] CMD_READ               = 4'b0101;
    localparam logic [3:0] CMD_BURST_TERM         = 4'b0110;

    localparam logic [1:0]  NOP_BA   = 2'b11;
    localparam logic [12:0] NOP_ADDR = 13'h1fff;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } sdram_bus_t;

    localparam sdram_bus_t NOP_BUS = '{cmd: CMD_NOP, ba: NOP_BA, addr: NOP_ADDR};

endpackage

// File: rtl/sdram_arbiter.sv
// SDRAM pin owner: passes init commands through, then grants the bus to refresh,
// write or read (fixed priority, no preemption) with a forced release on a stuck grant.
//
//   state | meaning
//   INIT  | init sequencer drives the pins until i_init_done
//   ARBIT | NOP on the bus, pick aref > wr > rd
//   AREF  | auto-refresh controller owns the bus
//   WRITE | write controller owns the bus and DQ
//   READ  | read controller owns the bus
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    input  logic [3:0]        i_init_cmd,
    input  logic [1:0]        i_init_ba,
    input  logic [12:0]       i_init_addr,
    input  logic              i_init_done,
    input  logic              i_aref_req,
    input  logic              i_aref_end,
    input  logic [3:0]        i_aref_cmd,
    input  logic [1:0]        i_aref_ba,
    input  logic [12:0]       i_aref_addr,
    input  logic              i_wr_req,
    input  logic              i_wr_end,
    input  logic [3:0]        i_wr_cmd,
    input  logic [1:0]        i_wr_ba,
    input  logic [12:0]       i_wr_addr,
    input  logic              i_wr_sdram_en,
    input  logic [DATA_W-1:0] i_wr_sdram_data,
    input  logic              i_rd_req,
    input  logic              i_rd_end,
    input  logic [3:0]        i_rd_cmd,
    input  logic [1:0]        i_rd_ba,
    input  logic [12:0]       i_rd_addr,
    output logic              o_aref_en,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic              o_sdram_cke,
    output logic              o_sdram_cs_n,
    output logic              o_sdram_ras_n,
    output logic              o_sdram_cas_n,
    output logic              o_sdram_we_n,
    output logic [1:0]        o_sdram_ba,
    output logic [12:0]       o_sdram_addr,
    output logic [DATA_W-1:0] o_sdram_dq_out,
    output logic              o_sdram_dq_oe,
    output logic              o_timeout_err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] busy_cnt;
    logic             grant_active;
    logic             end_pulse;
    logic             limit_hit;
    sdram_bus_t       bus;

    assign grant_active = (state == ST_AREF) || (state == ST_WRITE) || (state == ST_READ);
    // Grant lasts at most BUSY_TIMEOUT cycles: the counter starts at 0 on the first grant cycle.
    assign limit_hit = grant_active && (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1));

    always_comb begin
        end_pulse = 1'b0;
        case (state)
            ST_AREF:  end_pulse = i_aref_end;
            ST_WRITE: end_pulse = i_wr_end;
            ST_READ:  end_pulse = i_rd_end;
            default:  end_pulse = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (i_init_done) state_nxt = ST_ARBIT;
            ST_ARBIT: begin
                if (i_aref_req)    state_nxt = ST_AREF;
                else if (i_wr_req) state_nxt = ST_WRITE;
                else if (i_rd_req) state_nxt = ST_READ;
            end
            ST_AREF, ST_WRITE, ST_READ: if (end_pulse || limit_hit) state_nxt = ST_ARBIT;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            state         <= ST_INIT;
            busy_cnt      <= '0;
            o_timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= grant_active ? busy_cnt + CNT_W'(1) : '0;
            if (limit_hit && !end_pulse) o_timeout_err <= 1'b1;
        end
    end

    always_comb begin
        bus = NOP_BUS;
        case (state)
            ST_INIT:  bus = '{cmd: i_init_cmd, ba: i_init_ba, addr: i_init_addr};
            ST_AREF:  bus = '{cmd: i_aref_cmd, ba: i_aref_ba, addr: i_aref_addr};
            ST_WRITE: bus = '{cmd: i_wr_cmd,   ba: i_wr_ba,   addr: i_wr_addr};
            ST_READ:  bus = '{cmd: i_rd_cmd,   ba: i_rd_ba,   addr: i_rd_addr};
            default:  bus = NOP_BUS;
        endcase
    end

    assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = bus.cmd;
    assign o_sdram_ba     = bus.ba;
    assign o_sdram_addr   = bus.addr;
    assign o_sdram_cke    = 1'b1;
    assign o_aref_en      = (state == ST_AREF);
    assign o_wr_en        = (state == ST_WRITE);
    assign o_rd_en        = (state == ST_READ);
    assign o_sdram_dq_oe  = (state == ST_WRITE) && i_wr_sdram_en;
    assign o_sdram_dq_out = (state == ST_WRITE) ? i_wr_sdram_data : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: stimulus pushes the expected pin image per checked
// cycle into a queue, a negedge monitor pops and compares against the DUT.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        init_done;
    logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n, dq_oe, timeout_err;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq_out;

    localparam logic [3:0]  AREF_CMD = 4'b0001;
    localparam logic [1:0]  AREF_BA  = 2'b10;
    localparam logic [12:0] AREF_AD  = 13'h0aaa;
    localparam logic [3:0]  WR_CMD   = 4'b0100;
    localparam logic [1:0]  WR_BA    = 2'b01;
    localparam logic [12:0] WR_AD    = 13'h0123;
    localparam logic [3:0]  RD_CMD   = 4'b0101;
    localparam logic [1:0]  RD_BA    = 2'b10;
    localparam logic [12:0] RD_AD    = 13'h0456;

    sdram_arbiter #(.DATA_W(16), .BUSY_TIMEOUT(1023)) dut (
        .i_sysclk(clk), .i_sysrst(rst),
        .i_init_cmd(init_cmd), .i_init_ba(init_ba), .i_init_addr(init_addr),
        .i_init_done(init_done),
        .i_aref_req(aref_req), .i_aref_end(aref_end),
        .i_aref_cmd(AREF_CMD), .i_aref_ba(AREF_BA), .i_aref_addr(AREF_AD),
        .i_wr_req(wr_req), .i_wr_end(wr_end),
        .i_wr_cmd(WR_CMD), .i_wr_ba(WR_BA), .i_wr_addr(WR_AD),
        .i_wr_sdram_en(wr_sdram_en), .i_wr_sdram_data(wr_sdram_data),
        .i_rd_req(rd_req), .i_rd_end(rd_end),
        .i_rd_cmd(RD_CMD), .i_rd_ba(RD_BA), .i_rd_addr(RD_AD),
        .o_aref_en(aref_en), .o_wr_en(wr_en), .o_rd_en(rd_en),
        .o_sdram_cke(cke), .o_sdram_cs_n(cs_n), .o_sdram_ras_n(ras_n),
        .o_sdram_cas_n(cas_n), .o_sdram_we_n(we_n),
        .o_sdram_ba(ba), .o_sdram_addr(addr),
        .o_sdram_dq_out(dq_out), .o_sdram_dq_oe(dq_oe),
        .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [40:0] v;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // {cke, aref_en, wr_en, rd_en, cmd, ba, addr, dq_oe, dq_out, err}
    function automatic logic [40:0] mk(logic [2:0] en, logic [3:0] cmd, logic [1:0] b,
                                       logic [12:0] a, logic oe, logic [15:0] dq, logic err);
        return {1'b1, en, cmd, b, a, oe, dq, err};
    endfunction

    function automatic logic [40:0] nop(logic err);
        return mk(3'b000, 4'b0111, 2'b11, 13'h1fff, 1'b0, 16'h0000, err);
    endfunction

    function automatic logic [40:0] init_bus();
        return mk(3'b000, 4'b0010, 2'b01, 13'h0400, 1'b0, 16'h0000, 1'b0);
    endfunction

    function automatic logic [40:0] aref_bus(logic err);
        return mk(3'b100, AREF_CMD, AREF_BA, AREF_AD, 1'b0, 16'h0000, err);
    endfunction

    function automatic logic [40:0] wr_bus(logic oe, logic [15:0] dq, logic err);
        return mk(3'b010, WR_CMD, WR_BA, WR_AD, oe, dq, err);
    endfunction

    function automatic logic [40:0] rd_bus(logic err);
        return mk(3'b001, RD_CMD, RD_BA, RD_AD, 1'b0, 16'h0000, err);
    endfunction

    task automatic expect_v(input string name, input logic [40:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        logic [40:0] obs;
        exp_t        e;
        obs = {cke, aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n, ba, addr, dq_oe, dq_out,
               timeout_err};
        while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %h expected %h", e.name, cyc, obs, e.v);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400; init_done = 1'b0;
        aref_req = 1'b0; aref_end = 1'b0; wr_req = 1'b0; wr_end = 1'b0;
        rd_req = 1'b0; rd_end = 1'b0; wr_sdram_en = 1'b0; wr_sdram_data = 16'h0000;

        repeat (2) next_cycle();
        next_cycle();
        cyc = 0;
        rst = 1'b0;
        expect_v("reset_init_bus", init_bus());

        for (int c = 1; c <= 50; c++) begin
            next_cycle();
            init_done = (c == 50);
            expect_v("init_passthrough", init_bus());
        end

        next_cycle();   // 51: ARBIT
        init_done = 1'b0;
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        expect_v("arbit_nop", nop(1'b0));

        next_cycle();   // 52
        aref_req = 1'b0; wr_end = 1'b1;
        expect_v("aref_first", aref_bus(1'b0));

        next_cycle();   // 53: foreign wr_end ignored
        wr_end = 1'b0; aref_end = 1'b1;
        expect_v("aref_ignores_wr_end", aref_bus(1'b0));

        next_cycle();   // 54
        aref_end = 1'b0;
        expect_v("gap_after_aref", nop(1'b0));

        next_cycle();   // 55
        wr_sdram_en = 1'b1; wr_sdram_data = 16'ha5a5; aref_req = 1'b1; rd_end = 1'b1;
        expect_v("wr_grant_dq", wr_bus(1'b1, 16'ha5a5, 1'b0));

        next_cycle();   // 56: refresh pending, no preemption
        rd_end = 1'b0; wr_sdram_en = 1'b0; wr_req = 1'b0; wr_end = 1'b1;
        expect_v("wr_held_aref_pending", wr_bus(1'b0, 16'ha5a5, 1'b0));

        next_cycle();   // 57
        wr_end = 1'b0;
        expect_v("gap_after_wr", nop(1'b0));

        next_cycle();   // 58
        aref_req = 1'b0; aref_end = 1'b1;
        expect_v("aref_beats_rd", aref_bus(1'b0));

        next_cycle();   // 59
        aref_end = 1'b0;
        expect_v("gap_after_aref2", nop(1'b0));

        next_cycle();   // 60: READ, DQ must stay off
        rd_req = 1'b0; wr_sdram_en = 1'b1;
        expect_v("rd_grant_no_dq", rd_bus(1'b0));

        for (int k = 1; k <= 1022; k++) begin
            next_cycle();
            if (k == 1) begin
                wr_sdram_en = 1'b0;
                expect_v("rd_hold", rd_bus(1'b0));
            end
            if (k == 1022) expect_v("rd_last_before_timeout", rd_bus(1'b0));
        end

        next_cycle();   // 1083
        wr_req = 1'b1;
        expect_v("timeout_release", nop(1'b1));

        next_cycle();   // 1084
        wr_req = 1'b0;
        expect_v("served_after_timeout", wr_bus(1'b0, 16'ha5a5, 1'b1));

        next_cycle();   // 1085
        rst = 1'b1;
        expect_v("err_sticky", wr_bus(1'b0, 16'ha5a5, 1'b1));

        next_cycle();   // 1086
        rst = 1'b0;
        expect_v("reset_mid_write", init_bus());

        next_cycle();   // 1087
        init_done = 1'b1;
        expect_v("reinit_hold", init_bus());

        next_cycle();   // 1088
        rd_req = 1'b1;
        expect_v("rearbit_nop", nop(1'b0));

        next_cycle();   // 1089
        rd_req = 1'b0;
        expect_v("rd_grant2", rd_bus(1'b0));

        for (int k = 1; k <= 1022; k++) begin
            next_cycle();
            if (k == 1022) begin
                rd_end = 1'b1;
                expect_v("rd_end_at_limit", rd_bus(1'b0));
            end
        end

        next_cycle();   // 2112
        rd_end = 1'b0;
        expect_v("end_at_limit_no_err", nop(1'b0));

        next_cycle();   // 2113
        expect_v("idle_stays_arbit", nop(1'b0));

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
